// File: rtl/alu_seq.sv
// Sequential N-bit ALU with valid/ready handshakes, registered flags and a shift-add multiplier.
// Optional accumulator operand source is enabled by defining ALU_SEQ_ACC_EN.
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         acc_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Single-cycle ops; returns {carry, overflow, result}.
  function automatic logic [N+1:0] alu_eval(input logic [2:0]   f_op,
                                            input logic [N-1:0] f_a,
                                            input logic [N-1:0] f_b);
    logic        [N:0]   ext;
    logic        [N-1:0] r;
    logic                c;
    logic                v;
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;
    sa  = f_a;
    sb  = f_b;
    ext = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (f_op)
      OP_ADD: begin
        ext = {1'b0, f_a} + {1'b0, f_b};
        r   = ext[N-1:0];
        c   = ext[N];
        v   = (f_a[N-1] == f_b[N-1]) && (r[N-1] != f_a[N-1]);
      end
      OP_SUB: begin
        ext = {1'b0, f_a} - {1'b0, f_b};
        r   = ext[N-1:0];
        c   = ext[N];
        v   = (f_a[N-1] != f_b[N-1]) && (r[N-1] != f_a[N-1]);
      end
      OP_AND:  r = f_a & f_b;
      OP_OR:   r = f_a | f_b;
      OP_XOR:  r = f_a ^ f_b;
      OP_SLT:  r = {{(N-1){1'b0}}, (sa < sb)};
      OP_EQ:   r = {{(N-1){1'b0}}, (f_a == f_b)};
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  // One shift-add iteration: conditionally add multiplicand to the upper half, shift right.
  function automatic logic [2*N-1:0] mul_step(input logic [2*N-1:0] p,
                                              input logic [N-1:0]   m);
    logic [N:0] s;
    if (p[0]) s = {1'b0, p[2*N-1:N]} + {1'b0, m};
    else      s = {1'b0, p[2*N-1:N]};
    return {s, p[N-1:1]};
  endfunction

  state_t         state_q,     state_d;
  logic [N-1:0]   result_q,    result_d;
  logic           carry_q,     carry_d;
  logic           overflow_q,  overflow_d;
  logic           zero_q,      zero_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q,  in_ready_d;
  logic           busy_q,      busy_d;
  logic [N-1:0]   mcand_q,     mcand_d;
  logic [2*N-1:0] prod_q,      prod_d;
  logic [CW-1:0]  cnt_q,       cnt_d;

  logic [N-1:0]   opa;
  logic [N+1:0]   ev;
  logic [2*N-1:0] prod_nxt;

`ifdef ALU_SEQ_ACC_EN
  logic [N-1:0]   acc_q, acc_d;
  assign opa = acc_sel ? acc_q : a;
`else
  logic unused_acc_sel;
  assign unused_acc_sel = acc_sel;
  assign opa = a;
`endif

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
`ifdef ALU_SEQ_ACC_EN
    acc_d       = acc_q;
`endif
    ev          = alu_eval(op, opa, b);
    prod_nxt    = mul_step(prod_q, mcand_q);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (op == OP_MUL) begin
            state_d = S_EXEC;
            mcand_d = opa;
            prod_d  = {{N{1'b0}}, b};
            cnt_d   = '0;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = ev[N-1:0];
            carry_d     = ev[N+1];
            overflow_d  = ev[N];
            zero_d      = (ev[N-1:0] == '0);
          end
        end
      end
      S_EXEC: begin
        prod_d = prod_nxt;
        cnt_d  = cnt_q + CW'(1);
        // The last iteration writes the product straight into the output registers.
        if (cnt_q == CW'(N - 1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = prod_nxt[N-1:0];
          carry_d     = |prod_nxt[2*N-1:N];
          overflow_d  = 1'b0;
          zero_d      = (prod_nxt[N-1:0] == '0);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
`ifdef ALU_SEQ_ACC_EN
          acc_d       = result_q;
`endif
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
`ifdef ALU_SEQ_ACC_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
`ifdef ALU_SEQ_ACC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int N = 8;
  localparam longint MOD  = 64'd1 << N;
  localparam longint HALF = 64'd1 << (N - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

`ifdef ALU_SEQ_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         acc_sel;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         busy;

  int           n_checks;
  int           n_errors;
  logic [N-1:0] acc_m;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_sel   (acc_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {carry, overflow, result} from integer arithmetic on the operand values.
  function automatic logic [N+1:0] model(input logic [2:0] f_op, input logic [N-1:0] x,
                                         input logic [N-1:0] y);
    longint ux, uy, sx, sy, full, r;
    logic   c, v;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= HALF) ? ux - MOD : ux;
    sy = (uy >= HALF) ? uy - MOD : uy;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (f_op)
      OP_ADD: begin
        full = ux + uy;
        r = full % MOD;
        c = (full >= MOD);
        v = (sx + sy > HALF - 1) || (sx + sy < -HALF);
      end
      OP_SUB: begin
        r = (ux - uy + MOD) % MOD;
        c = (ux < uy);
        v = (sx - sy > HALF - 1) || (sx - sy < -HALF);
      end
      OP_AND: r = longint'(x & y);
      OP_OR:  r = longint'(x | y);
      OP_XOR: r = longint'(x ^ y);
      OP_SLT: r = (sx < sy) ? 1 : 0;
      OP_EQ:  r = (ux == uy) ? 1 : 0;
      default: begin
        full = ux * uy;
        r = full % MOD;
        c = (full >= MOD);
      end
    endcase
    return {c, v, N'(r)};
  endfunction

  task automatic run_op(input logic [2:0] t_op, input logic [N-1:0] t_a, input logic [N-1:0] t_b,
                        input logic t_sel, input int hold, output logic [N-1:0] got);
    logic [N+1:0] exp;
    logic [N-1:0] opa;
    int           lat;
    int           guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_req", 32'(in_ready), 32'd1);
    opa = (ACC_EN && t_sel) ? acc_m : t_a;
    exp = model(t_op, opa, t_b);
    op = t_op; a = t_a; b = t_b; acc_sel = t_sel;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = N'($urandom); b = N'($urandom); acc_sel = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 4 * N) begin
      check("busy_exec", 32'({busy, in_ready}), 32'b10);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), (t_op == OP_MUL) ? 32'(N + 1) : 32'd1);
    check("result", 32'(result), 32'(exp[N-1:0]));
    check("carry", 32'(carry), 32'(exp[N+1]));
    check("overflow", 32'(overflow), 32'(exp[N]));
    check("zero", 32'(zero), 32'(exp[N-1:0] == '0));
    got = result;
    // Backpressure: a competing request must be ignored and the outputs must hold.
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op = 3'($urandom); a = N'($urandom); b = N'($urandom);
      @(posedge clk); #1;
      check("hold_in_ready", 32'({in_ready, out_valid, busy}), 32'b011);
      check("hold_result", 32'({carry, overflow, zero, result}), 32'({exp[N+1], exp[N], exp[N-1:0] == '0, exp[N-1:0]}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_handshake", 32'({out_valid, in_ready, busy}), 32'b010);
    acc_m = exp[N-1:0];
  endtask

  initial begin
    logic [N-1:0] got;
    logic [2:0]   r_op;
    n_checks = 0;
    n_errors = 0;
    acc_m = '0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0; a = '0; b = '0; acc_sel = 1'b0;
    #23;
    check("reset_state", 32'({out_valid, busy, in_ready, carry, overflow, zero}), 32'b001001);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(OP_ADD, 8'h7F, 8'h01, 1'b0, 0, got);
    check("add_7f_01", 32'(got), 32'h80);
    run_op(OP_SUB, 8'h00, 8'h01, 1'b0, 0, got);
    check("sub_00_01", 32'(got), 32'hFF);
    run_op(OP_SUB, 8'h80, 8'h01, 1'b0, 0, got);
    run_op(OP_MUL, 8'h10, 8'h11, 1'b0, 0, got);
    check("mul_10_11", 32'(got), 32'h10);
    run_op(OP_MUL, 8'h0F, 8'h03, 1'b0, 0, got);
    check("mul_0f_03", 32'(got), 32'h2D);
    run_op(OP_EQ, 8'h55, 8'h55, 1'b0, 5, got);
    run_op(OP_SLT, 8'hFF, 8'h01, 1'b0, 0, got);
    run_op(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1, got);
    run_op(OP_ADD, 8'h05, 8'h03, 1'b0, 0, got);
    run_op(OP_ADD, 8'h20, 8'h02, 1'b1, 0, got);
`ifdef ALU_SEQ_ACC_EN
    check("acc_operand", 32'(got), 32'h0A);
`else
    check("acc_operand", 32'(got), 32'h22);
`endif

    // Reset in the middle of a multiply.
    op = OP_MUL; a = 8'h33; b = 8'h07; acc_sel = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midmul_reset", 32'({out_valid, busy, in_ready, zero, carry}), 32'b00110);
    check("midmul_result", 32'(result), 32'd0);
    acc_m = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("no_result_after_reset", 32'({out_valid, busy, in_ready}), 32'b001);
    end
    check("post_reset_result", 32'({zero, result}), 32'({1'b1, 8'h00}));

    for (int i = 0; i < 80; i++) begin
      r_op = 3'($urandom);
      run_op(r_op, N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
